alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Initiator side of the 8-bit ALU datapath: collects operand A, operand B and the 2-bit opcode one at a time from a shared data bus.
- Each field is captured on a load-button press and driven to the combinational ALU.
- One cycle after the opcode is captured, the block registers the ALU's Result and Flags and holds them for display.
- Sits between the debounced switch/button inputs and the ALU instance on the lab board top level.

Parameters:
- M, 8, operand/result width; must match the ALU's M.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  M  switch bus; the full width is A or B, and data_in[1:0] is the opcode.
- load  input  1  level from the debounced button, synchronous to clk; only its rising edge acts.
- alu_result  input  M  Result from the ALU.
- alu_flags  input  5  Flags from the ALU, as {N,Z,C,V,P} (bit4 to bit0).
- op_a  output  M  registered operand A driven to the ALU.
- op_b  output  M  registered operand B driven to the ALU.
- op_code  output  2  registered opcode: 00 SUB, 01 ADD, 10 OR, 11 AND.
- result_q  output  M  latched ALU result.
- flags_q  output  5  latched ALU flags.
- result_valid  output  1  high while result_q/flags_q hold the current operation's outcome.
- state_o  output  3  current FSM state encoding, for LEDs.
- op_count  output  CNT_W  number of completed operations.

Behaviour:
- Reset (rst_n low, asynchronous):
  - op_a, op_b, op_code, result_q, flags_q, result_valid and op_count are all 0.
  - state is LOAD_A.
  - load_d (the edge-detect register) resets to 1, so a button held through reset does not trigger.
- Edge detect: load_rise = load & ~load_d; load_d <= load every cycle.
- States and encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, DONE=4. Codes 5-7 are illegal and go to LOAD_A on the next clock.
- LOAD_A: on load_rise, op_a <= data_in, result_valid <= 0, go to LOAD_B.
- LOAD_B: on load_rise, op_b <= data_in, go to LOAD_OP.
- LOAD_OP: on load_rise, op_code <= data_in[1:0], go to EXEC. data_in[M-1:2] is ignored.
- EXEC (exactly one cycle; load_rise is ignored):
  - result_q <= alu_result, flags_q <= alu_flags.
  - result_valid <= 1.
  - op_count <= op_count+1, wrapping from 2^CNT_W-1 to 0.
  - Go to DONE.
- DONE: result_q, flags_q and result_valid hold. On load_rise, go to LOAD_A. result_valid stays 1 until the next A capture.
- Latency: result_valid rises 2 clocks after the load_rise that captures the opcode (capture edge, then EXEC edge).
- op_a, op_b and op_code are stable from the capture edge onward, so the combinational ALU settles before the EXEC sample.
- Without load_rise, every state holds indefinitely.
- Reset mid-sequence: partial operands are discarded and the FSM returns to LOAD_A with all outputs at their reset values.
- data_in changes are never sampled outside a load_rise.

Optional Feature:
- Macro ALU_SEQ_ACCUM_EN.
- When defined: on load_rise in DONE, op_a <= result_q and the FSM goes to LOAD_B, skipping LOAD_A. Results chain, e.g. running sums. result_valid is cleared on that transition.
- When undefined: DONE returns to LOAD_A as specified above.
- Port list is identical in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum state_t (3-bit, values as listed above);
  - opcode constants OP_SUB=2'b00, OP_ADD=2'b01, OP_OR=2'b10, OP_AND=2'b11;
  - flag index constants FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_P=0.
- One sub-module, rise_detect: 1-bit rising-edge detector with async active-low reset and a reset value of 1. It is instantiated for load.

Test Plan:
- M=8, ALU instantiated in the bench. Presses: 0x7F, 0x01, 0x01 (ADD) -> 2 clocks after the third press, result_q=0x80, flags_q=5'b10011, result_valid=1, op_count=1.
- Presses: 0x05, 0x05, 0x00 (SUB) -> result_q=0x00, flags_q=5'b01000.
- Presses: 0x03, 0x05, 0x00 (SUB) -> result_q=0xFE, flags_q=5'b10101 (C=1, V=0, P=1).
- load held high for 20 cycles during LOAD_B -> exactly one capture. Hold load high through rst_n release -> no capture until load falls and rises again.
- rst_n pulsed low during LOAD_OP after A=0xAA, B=0x55 captured -> all outputs 0 immediately (asynchronously), state_o=0.
- With ALU_SEQ_ACCUM_EN: after the 0x80 result, press 0x01, 0x01 -> op_a=0x80, result_q=0x81, op_count=2. Without the macro, the same presses load A=0x01 and B=0x01.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operand sequencer.
//   state_t    - FSM state encoding. These values also appear on the state LEDs.
//   OP_*       - 2-bit ALU opcodes.
//   FLAG_*     - bit positions inside the 5-bit {N,Z,C,V,P} flag word.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

endpackage

// File: rtl/alu_operand_sequencer_rise_detect.sv
// rise_detect: 1-bit rising-edge detector.
//   clk, rst_n - clock and asynchronous active-low reset
//   sig_i      - level input, already synchronous to clk
//   rise_o     - high for one cycle when sig_i goes from 0 to 1
// The history flop resets to 1. An input that is held high through reset
// therefore gives no pulse until it has gone low and then high again.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples values from before the clock edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects operand A, operand B and the opcode from a
// shared switch bus, one field per button press. It drives them to a
// combinational ALU and then latches the ALU's result and flags.
//   clk, rst_n    - clock and asynchronous active-low reset
//   data_in       - switch bus. The full width carries A or B; [1:0] carries the opcode.
//   load          - debounced button level. Only its rising edge acts.
//   alu_result    - result input from the ALU
//   alu_flags     - flag input from the ALU, {N,Z,C,V,P}
//   op_a, op_b    - registered operands driven to the ALU
//   op_code       - registered opcode driven to the ALU
//   result_q      - latched ALU result
//   flags_q       - latched ALU flags
//   result_valid  - result_q and flags_q hold the current operation's outcome
//   state_o       - FSM state code, for the LEDs
//   op_count      - number of completed operations; wraps to 0
// Build option: define ALU_SEQ_ACCUM_EN to chain results. A press in DONE then
// copies result_q into operand A and goes straight to LOAD_B.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int M     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M-1:0]     data_in,
  input  logic             load,
  input  logic [M-1:0]     alu_result,
  input  logic [4:0]       alu_flags,
  output logic [M-1:0]     op_a,
  output logic [M-1:0]     op_b,
  output logic [1:0]       op_code,
  output logic [M-1:0]     result_q,
  output logic [4:0]       flags_q,
  output logic             result_valid,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_d;
  logic [M-1:0]     op_a_q, op_a_d;
  logic [M-1:0]     op_b_q, op_b_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [M-1:0]     result_d;
  logic [4:0]       flags_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             load_rise;

  rise_detect u_load_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (load),
    .rise_o (load_rise)
  );

  // NOTE: every _d signal starts as its _q value, so every path through the
  // case assigns it and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_code_d      = op_code_q;
    result_d       = result_q;
    flags_d        = flags_q;
    result_valid_d = result_valid_q;
    op_count_d     = op_count_q;

    unique case (state_q)
      LOAD_A: if (load_rise) begin
        op_a_d         = data_in;
        result_valid_d = 1'b0;
        state_d        = LOAD_B;
      end
      LOAD_B: if (load_rise) begin
        op_b_d  = data_in;
        state_d = LOAD_OP;
      end
      LOAD_OP: if (load_rise) begin
        op_code_d = data_in[1:0];
        state_d   = EXEC;
      end
      // The operands have been stable since their capture edges, so the ALU
      // output has settled by the time it is sampled here.
      EXEC: begin
        result_d       = alu_result;
        flags_d        = alu_flags;
        result_valid_d = 1'b1;
        op_count_d     = op_count_q + CNT_W'(1);
        state_d        = DONE;
      end
      DONE: if (load_rise) begin
`ifdef ALU_SEQ_ACCUM_EN
        op_a_d         = result_q;
        result_valid_d = 1'b0;
        state_d        = LOAD_B;
`else
        state_d        = LOAD_A;
`endif
      end
      // Codes 5-7 cannot be reached in normal operation. Return to LOAD_A if one appears.
      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: every register, including the operand and result holding registers,
  // is reset. A reset in mid-sequence then leaves no partial operands behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_code_q      <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_code_q      <= op_code_d;
      result_q       <= result_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      op_count_q     <= op_count_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_code      = op_code_q;
  assign result_valid = result_valid_q;
  assign state_o      = state_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer. It contains a small combinational ALU,
// directed vectors and randomized operations. Expected values come from an
// integer-arithmetic reference kept here in the bench.
module tb_alu_operand_sequencer;

  localparam int M     = 8;
  localparam int CNT_W = 8;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [M-1:0]     data_in = '0;
  logic             load = 1'b0;
  logic [M-1:0]     alu_result;
  logic [4:0]       alu_flags;
  logic [M-1:0]     op_a, op_b, result_q;
  logic [1:0]       op_code;
  logic [4:0]       flags_q;
  logic             result_valid;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int m_count  = 0;   // completed operations since the last reset
  int m_res    = 0;   // result of the last completed operation

  always #5 clk = ~clk;

  alu_operand_sequencer #(.M(M), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .load         (load),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_code      (op_code),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .result_valid (result_valid),
    .state_o      (state_o),
    .op_count     (op_count)
  );

  // Combinational ALU on the board, driven by the sequencer's operand registers.
  always_comb begin
    logic [M:0] wide;
    logic       v;
    wide = '0;
    v    = 1'b0;
    case (op_code)
      2'b00: begin
        wide = {1'b0, op_a} - {1'b0, op_b};
        v    = (op_a[M-1] != op_b[M-1]) && (wide[M-1] != op_a[M-1]);
      end
      2'b01: begin
        wide = {1'b0, op_a} + {1'b0, op_b};
        v    = (op_a[M-1] == op_b[M-1]) && (wide[M-1] != op_a[M-1]);
      end
      2'b10:   wide = {1'b0, op_a | op_b};
      default: wide = {1'b0, op_a & op_b};
    endcase
    alu_result = wide[M-1:0];
    alu_flags  = {wide[M-1], wide[M-1:0] == '0, wide[M], v, ^wide[M-1:0]};
  end

  // Reference: returns {flags, result} computed with plain integer arithmetic.
  function automatic logic [12:0] ref_alu(int a, int b, int op);
    int r, c, v, n, z, p;
    c = 0;
    v = 0;
    case (op)
      0: begin
        r = (a - b + 256) % 256;
        c = (a < b) ? 1 : 0;
        v = ((a >= 128) != (b >= 128) && (r >= 128) != (a >= 128)) ? 1 : 0;
      end
      1: begin
        r = (a + b) % 256;
        c = (a + b > 255) ? 1 : 0;
        v = ((a >= 128) == (b >= 128) && (r >= 128) != (a >= 128)) ? 1 : 0;
      end
      2: r = a | b;
      default: r = a & b;
    endcase
    n = (r >= 128) ? 1 : 0;
    z = (r == 0) ? 1 : 0;
    p = $countones(r) % 2;
    return {n[0], z[0], c[0], v[0], p[0], r[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Holds load high for one cycle with val on the bus, then scrambles the bus.
  // Returns at the falling edge after the capturing rising edge.
  task automatic press(input logic [M-1:0] val);
    @(negedge clk);
    data_in = val;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    data_in = M'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'(S_A));
    check("rst_op_a", 32'(op_a), 0);
    check("rst_op_b", 32'(op_b), 0);
    check("rst_op_code", 32'(op_code), 0);
    check("rst_result", 32'(result_q), 0);
    check("rst_flags", 32'(flags_q), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_count", 32'(op_count), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_count = 0;
    m_res   = 0;
  endtask

  // Captures B and the opcode, then checks EXEC and DONE against the reference.
  task automatic run_from_b(input int a, input int b, input int op);
    logic [M-1:0] opword;
    logic [12:0]  exp;
    press(M'(b));
    check("capt_b", 32'(op_b), 32'(b));
    check("state_after_b", 32'(state_o), 32'(S_OP));
    opword      = M'($urandom);
    opword[1:0] = op[1:0];
    press(opword);
    check("capt_op", 32'(op_code), 32'(op));
    check("hold_a", 32'(op_a), 32'(a));
    check("state_exec", 32'(state_o), 32'(S_EXEC));
    @(negedge clk);
    exp = ref_alu(a, b, op);
    m_count++;
    m_res = int'(exp[7:0]);
    check("result", 32'(result_q), 32'(exp[7:0]));
    check("flags", 32'(flags_q), 32'(exp[12:8]));
    check("valid", 32'(result_valid), 1);
    check("count", 32'(op_count), 32'(m_count % 256));
    check("state_done", 32'(state_o), 32'(S_DONE));
  endtask

  task automatic run_op(input int a, input int b, input int op);
    press(M'(a));
    check("capt_a", 32'(op_a), 32'(a));
    check("valid_cleared", 32'(result_valid), 0);
    check("state_after_a", 32'(state_o), 32'(S_B));
    run_from_b(a, b, op);
  endtask

  // Press in DONE. The build option decides where this press leads.
  task automatic leave_done();
    press(M'($urandom));
`ifdef ALU_SEQ_ACCUM_EN
    check("accum_state", 32'(state_o), 32'(S_B));
    check("accum_op_a", 32'(op_a), 32'(m_res));
    check("accum_valid", 32'(result_valid), 0);
`else
    check("done_state", 32'(state_o), 32'(S_A));
    check("done_valid_hold", 32'(result_valid), 1);
    check("done_result_hold", 32'(result_q), 32'(m_res));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors from the test plan, each starting from reset.
    do_reset();
    run_op(8'h05, 8'h05, 0);
    check("sub_eq_res", 32'(result_q), 32'h00);
    check("sub_eq_flags", 32'(flags_q), 32'b01000);

    do_reset();
    run_op(8'h03, 8'h05, 0);
    check("sub_neg_res", 32'(result_q), 32'hFE);
    check("sub_neg_flags", 32'(flags_q), 32'b10101);

    // With load held high, only one capture occurs.
    do_reset();
    press(8'h11);
    @(negedge clk);
    data_in = 8'h3C;
    load    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_in = M'($urandom);
    end
    load = 1'b0;
    check("held_b", 32'(op_b), 32'h3C);
    check("held_state", 32'(state_o), 32'(S_OP));
    press(8'h01);
    @(negedge clk);
    check("held_result", 32'(result_q), 32'h4D);

    // Load held high through reset release: no capture until a new rising edge.
    @(negedge clk);
    load    = 1'b1;
    data_in = 8'h99;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0;
    repeat (5) @(negedge clk);
    check("rsthold_state", 32'(state_o), 32'(S_A));
    check("rsthold_op_a", 32'(op_a), 0);
    load = 1'b0;
    run_op(8'h22, 8'h0F, 3);

    // Asynchronous reset in LOAD_OP discards the captured operands.
    do_reset();
    press(8'hAA);
    press(8'h55);
    check("mid_state", 32'(state_o), 32'(S_OP));
    do_reset();

    // Add that overflows, followed by one chained or fresh operation.
    run_op(8'h7F, 8'h01, 1);
    check("add_ovf_res", 32'(result_q), 32'h80);
    check("add_ovf_flags", 32'(flags_q), 32'b10011);
    check("add_ovf_count", 32'(op_count), 1);
    leave_done();
`ifdef ALU_SEQ_ACCUM_EN
    run_from_b(8'h80, 8'h01, 1);
    check("chain_res", 32'(result_q), 32'h81);
`else
    run_op(8'h01, 8'h01, 1);
    check("fresh_res", 32'(result_q), 32'h02);
`endif
    check("count_two", 32'(op_count), 2);

    // Random operations. The loop runs long enough for op_count to wrap.
    for (int i = 0; i < 270; i++) begin
      int ra, rb, rop;
      ra  = int'($urandom_range(255));
      rb  = int'($urandom_range(255));
      rop = int'($urandom_range(3));
      leave_done();
      if ($urandom_range(3) == 0) repeat (int'($urandom_range(4))) @(negedge clk);
`ifdef ALU_SEQ_ACCUM_EN
      run_from_b(m_res, rb, rop);
`else
      run_op(ra, rb, rop);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
